// File: rtl/sal_rw_arb.sv
// Read/write request arbiter: batches requests by direction, bounds each batch
// for fairness, inserts a programmable turnaround gap on every direction
// switch and presents one registered request per cycle to the scheduler.
module sal_rw_arb #(
    parameter int ADDR_W   = 32,
    parameter int ID_W     = 4,
    parameter int RD_BATCH = 8,
    parameter int WR_BATCH = 8,
    parameter int TURN_CYC = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rd_req_valid,
    output logic              rd_req_ready,
    input  logic [ID_W-1:0]   rd_req_id,
    input  logic [ADDR_W-1:0] rd_req_addr,
    input  logic              wr_req_valid,
    output logic              wr_req_ready,
    input  logic [ID_W-1:0]   wr_req_id,
    input  logic [ADDR_W-1:0] wr_req_addr,
    input  logic              wr_data_avail,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_is_wr,
    output logic [ID_W-1:0]   out_id,
    output logic [ADDR_W-1:0] out_addr,
    output logic [1:0]        mode
);
    localparam int BMAX = (RD_BATCH > WR_BATCH) ? RD_BATCH : WR_BATCH;
    localparam int BW   = $clog2(BMAX + 1);
    localparam logic [BW-1:0] RD_LIM = BW'(RD_BATCH);
    localparam logic [BW-1:0] WR_LIM = BW'(WR_BATCH);
    localparam logic [BW-1:0] ONE    = BW'(1);
    // The switch decision cycle is itself the first bubble, so the TURN
    // state only has to cover the remaining TURN_CYC-1 idle cycles.
    localparam logic [3:0] TURN_LOAD = (TURN_CYC > 1) ? 4'(TURN_CYC - 1) : 4'd0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        TURN = 2'd3
    } state_t;

    state_t          state_reg, state_next;
    logic [BW-1:0]   batch_cnt_reg, batch_cnt_next;
    logic [3:0]      turn_cnt_reg, turn_cnt_next;
    logic            turn_wr_reg, turn_wr_next;
    logic            grant_rd, grant_wr;
    logic            rd_elig, wr_elig, slot_free;
    logic            rd_cont, wr_cont;
    logic [BW-1:0]   rd_sat_inc, wr_sat_inc;

    assign rd_elig   = rd_req_valid;
    assign wr_elig   = wr_req_valid & wr_data_avail;
    assign slot_free = !out_valid | out_ready;

    // Staying in the current direction is allowed until the batch limit, or
    // indefinitely when the other direction has nothing eligible.
    assign rd_cont    = rd_elig && ((batch_cnt_reg < RD_LIM) || !wr_elig);
    assign wr_cont    = wr_elig && ((batch_cnt_reg < WR_LIM) || !rd_elig);
    assign rd_sat_inc = (batch_cnt_reg >= RD_LIM) ? RD_LIM : batch_cnt_reg + ONE;
    assign wr_sat_inc = (batch_cnt_reg >= WR_LIM) ? WR_LIM : batch_cnt_reg + ONE;

    assign rd_req_ready = grant_rd & rst_n;
    assign wr_req_ready = grant_wr & rst_n;
    assign mode         = state_reg;

    // State, batch and turnaround registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            batch_cnt_reg <= '0;
            turn_cnt_reg  <= '0;
            turn_wr_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            batch_cnt_reg <= batch_cnt_next;
            turn_cnt_reg  <= turn_cnt_next;
            turn_wr_reg   <= turn_wr_next;
        end
    end

    // Next-state and grant decision.
    always_comb begin
        state_next     = state_reg;
        batch_cnt_next = batch_cnt_reg;
        turn_cnt_next  = turn_cnt_reg;
        turn_wr_next   = turn_wr_reg;
        grant_rd       = 1'b0;
        grant_wr       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (slot_free) begin
                    if (rd_elig) begin
                        grant_rd       = 1'b1;
                        state_next     = RD;
                        batch_cnt_next = ONE;
                    end else if (wr_elig) begin
                        grant_wr       = 1'b1;
                        state_next     = WR;
                        batch_cnt_next = ONE;
                    end
                end
            end
            RD: begin
                if (rd_cont) begin
                    if (slot_free) begin
                        grant_rd       = 1'b1;
                        batch_cnt_next = rd_sat_inc;
                    end
                end else if (wr_elig) begin
                    if (TURN_CYC == 0) begin
                        if (slot_free) begin
                            grant_wr       = 1'b1;
                            state_next     = WR;
                            batch_cnt_next = ONE;
                        end
                    end else if (TURN_CYC == 1) begin
                        state_next     = WR;
                        batch_cnt_next = '0;
                    end else begin
                        state_next     = TURN;
                        turn_cnt_next  = TURN_LOAD;
                        turn_wr_next   = 1'b1;
                        batch_cnt_next = '0;
                    end
                end
            end
            WR: begin
                if (wr_cont) begin
                    if (slot_free) begin
                        grant_wr       = 1'b1;
                        batch_cnt_next = wr_sat_inc;
                    end
                end else if (rd_elig) begin
                    if (TURN_CYC == 0) begin
                        if (slot_free) begin
                            grant_rd       = 1'b1;
                            state_next     = RD;
                            batch_cnt_next = ONE;
                        end
                    end else if (TURN_CYC == 1) begin
                        state_next     = RD;
                        batch_cnt_next = '0;
                    end else begin
                        state_next     = TURN;
                        turn_cnt_next  = TURN_LOAD;
                        turn_wr_next   = 1'b0;
                        batch_cnt_next = '0;
                    end
                end
            end
            TURN: begin
                // Counts down regardless of backpressure; always lands in the
                // latched target even if that requester has gone away.
                if (turn_cnt_reg <= 4'd1) begin
                    state_next    = turn_wr_reg ? WR : RD;
                    turn_cnt_next = 4'd0;
                end else begin
                    turn_cnt_next = turn_cnt_reg - 4'd1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Output register: load on grant, hold while stalled, clear when drained.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_is_wr <= 1'b0;
            out_id    <= '0;
            out_addr  <= '0;
        end else if (grant_rd || grant_wr) begin
            out_valid <= 1'b1;
            out_is_wr <= grant_wr;
            out_id    <= grant_wr ? wr_req_id : rd_req_id;
            out_addr  <= grant_wr ? wr_req_addr : rd_req_addr;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_sal_rw_arb.sv
// Self-checking bench for sal_rw_arb: two instances (turnaround 2 and 0) share
// stimulus; each is compared every cycle with a reference model of the
// arbitration rules, plus directed checks for the documented scenarios.
module tb_sal_rw_arb;
    localparam int AW = 32;
    localparam int IW = 4;
    localparam int BATCH = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n = 1'b0;
    logic          rd_v = 1'b0, wr_v = 1'b0, wr_da = 1'b0, o_rdy = 1'b0;
    logic [IW-1:0] rd_id = '0, wr_id = '0;
    logic [AW-1:0] rd_addr = '0, wr_addr = '0;

    logic          rd_rdy [2];
    logic          wr_rdy [2];
    logic          ov [2];
    logic          owr [2];
    logic [IW-1:0] oid [2];
    logic [AW-1:0] oaddr [2];
    logic [1:0]    mode [2];

    sal_rw_arb #(.ADDR_W(AW), .ID_W(IW), .RD_BATCH(BATCH), .WR_BATCH(BATCH), .TURN_CYC(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .rd_req_valid(rd_v), .rd_req_ready(rd_rdy[0]), .rd_req_id(rd_id), .rd_req_addr(rd_addr),
        .wr_req_valid(wr_v), .wr_req_ready(wr_rdy[0]), .wr_req_id(wr_id), .wr_req_addr(wr_addr),
        .wr_data_avail(wr_da), .out_valid(ov[0]), .out_ready(o_rdy), .out_is_wr(owr[0]),
        .out_id(oid[0]), .out_addr(oaddr[0]), .mode(mode[0]));

    sal_rw_arb #(.ADDR_W(AW), .ID_W(IW), .RD_BATCH(BATCH), .WR_BATCH(BATCH), .TURN_CYC(0)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .rd_req_valid(rd_v), .rd_req_ready(rd_rdy[1]), .rd_req_id(rd_id), .rd_req_addr(rd_addr),
        .wr_req_valid(wr_v), .wr_req_ready(wr_rdy[1]), .wr_req_id(wr_id), .wr_req_addr(wr_addr),
        .wr_data_avail(wr_da), .out_valid(ov[1]), .out_ready(o_rdy), .out_is_wr(owr[1]),
        .out_id(oid[1]), .out_addr(oaddr[1]), .mode(mode[1]));

    // Reference model: current direction (0 none, 1 read, 2 write), grants in
    // the current batch, bubble cycles still owed, and the output slot.
    int            tc [2] = '{2, 0};
    int            m_dir [2];
    int            m_run [2];
    int            m_gap [2];
    logic          m_ov [2];
    logic          m_wr [2];
    logic [IW-1:0] m_id [2];
    logic [AW-1:0] m_addr [2];
    int            g_last [2];

    int checks = 0;
    int passed = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Whether the current direction keeps going under the batch rule.
    function automatic logic own_continues(int k);
        logic re, we, own_e, oth_e;
        re    = rd_v;
        we    = wr_v & wr_da;
        own_e = (m_dir[k] == 1) ? re : we;
        oth_e = (m_dir[k] == 1) ? we : re;
        return own_e && ((m_run[k] < BATCH) || !oth_e);
    endfunction

    // Predicted grant this cycle: bit0 = read, bit1 = write.
    function automatic logic [1:0] pred(int k);
        logic re, we, slot, oth_e;
        re   = rd_v;
        we   = wr_v & wr_da;
        slot = !m_ov[k] | o_rdy;
        if (!rst_n || m_gap[k] > 0 || !slot) return 2'b00;
        if (m_dir[k] == 0) return re ? 2'b01 : (we ? 2'b10 : 2'b00);
        oth_e = (m_dir[k] == 1) ? we : re;
        if (own_continues(k)) return (m_dir[k] == 1) ? 2'b01 : 2'b10;
        if (oth_e && tc[k] == 0) return (m_dir[k] == 1) ? 2'b10 : 2'b01;
        return 2'b00;
    endfunction

    task automatic model_step(input int k, input logic [1:0] g);
        int   ndir;
        logic oth_e;
        if (!rst_n) begin
            m_dir[k] = 0; m_run[k] = 0; m_gap[k] = 0;
            m_ov[k] = 1'b0; m_wr[k] = 1'b0; m_id[k] = '0; m_addr[k] = '0;
            return;
        end
        oth_e = (m_dir[k] == 1) ? (wr_v & wr_da) : rd_v;
        if (m_gap[k] > 0) begin
            m_gap[k]--;
        end else if (g != 2'b00) begin
            ndir = g[1] ? 2 : 1;
            if (ndir == m_dir[k]) m_run[k] = (m_run[k] + 1 > BATCH) ? BATCH : m_run[k] + 1;
            else begin m_dir[k] = ndir; m_run[k] = 1; end
        end else if (m_dir[k] != 0 && tc[k] > 0 && !own_continues(k) && oth_e) begin
            m_dir[k] = 3 - m_dir[k];
            m_run[k] = 0;
            m_gap[k] = tc[k] - 1;
        end
        if (g != 2'b00) begin
            m_ov[k]   = 1'b1;
            m_wr[k]   = g[1];
            m_id[k]   = g[1] ? wr_id : rd_id;
            m_addr[k] = g[1] ? wr_addr : rd_addr;
        end else if (o_rdy) begin
            m_ov[k] = 1'b0;
        end
    endtask

    // One clock cycle with inputs already driven: check readies, advance model,
    // then check the registered outputs after the edge.
    task automatic cyc();
        logic [1:0] g [2];
        logic [1:0] me;
        #1;
        for (int k = 0; k < 2; k++) begin
            g[k] = pred(k);
            chk($sformatf("ready%0d", k), {62'd0, rd_rdy[k], wr_rdy[k]}, {62'd0, g[k][0], g[k][1]});
            chk($sformatf("both_ready%0d", k), {63'd0, rd_rdy[k] & wr_rdy[k]}, 64'd0);
        end
        for (int k = 0; k < 2; k++) begin
            model_step(k, g[k]);
            g_last[k] = g[k][1] ? 2 : (g[k][0] ? 1 : 0);
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            me = (m_gap[k] > 0) ? 2'd3 : 2'(m_dir[k]);
            chk($sformatf("outputs%0d", k),
                {24'd0, ov[k], owr[k], oid[k], oaddr[k], mode[k]},
                {24'd0, m_ov[k], m_wr[k], m_id[k], m_addr[k], me});
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cyc();
        cyc();
        rst_n = 1'b1;
    endtask

    task automatic rand_fields();
        rd_id   = IW'($urandom);
        wr_id   = IW'($urandom);
        rd_addr = $urandom;
        wr_addr = $urandom;
    endtask

    initial begin
        int k;
        int ncyc;
        int p;
        int exp_g;

        // Reset, including a cycle with a read request present.
        do_reset();
        rd_v = 1'b1;
        rst_n = 1'b0;
        cyc();
        chk("reset_out_valid", {63'd0, ov[0]}, 64'd0);
        chk("reset_mode", {62'd0, mode[0]}, 64'd0);
        rst_n = 1'b1;

        // Twelve back-to-back reads at 0x20*k.
        o_rdy = 1'b1;
        k = 0;
        ncyc = 0;
        for (int i = 0; i < 40 && k < 12; i++) begin
            rd_v = 1'b1;
            rd_addr = AW'(32'h20 * k);
            rd_id = IW'($urandom);
            cyc();
            ncyc++;
            if (g_last[0] == 1) k++;
            chk("reads_mode", {62'd0, mode[0]}, 64'd1);
            chk("reads_addr", {32'd0, oaddr[0]}, {32'd0, AW'(32'h20 * (k - 1))});
        end
        chk("reads_cycles", 64'(ncyc), 64'd12);
        rd_v = 1'b0;
        cyc();

        // Both directions continuously eligible: 8R, 2 bubbles, 8W, 2 bubbles.
        do_reset();
        rd_v = 1'b1; wr_v = 1'b1; wr_da = 1'b1; o_rdy = 1'b1;
        for (int t = 0; t < 60; t++) begin
            rand_fields();
            cyc();
            p = t % 20;
            exp_g = (p < 8) ? 1 : (p < 10) ? 0 : (p < 18) ? 2 : 0;
            chk($sformatf("batch_pattern_t%0d", t), 64'(g_last[0]), 64'(exp_g));
        end

        // Write without data is never granted.
        rd_v = 1'b0; wr_v = 1'b0; wr_da = 1'b0;
        do_reset();
        wr_v = 1'b1;
        for (int t = 0; t < 20; t++) begin
            rand_fields();
            cyc();
        end
        chk("nodata_mode", {62'd0, mode[0]}, 64'd0);
        chk("nodata_out_valid", {63'd0, ov[0]}, 64'd0);
        wr_da = 1'b1;
        cyc();
        chk("data_write_granted", 64'(g_last[0]), 64'd2);
        chk("data_write_out", {62'd0, ov[0], owr[0]}, 64'd3);

        // Backpressure holds the output stable at 0x2008.
        wr_addr = 32'h2008;
        cyc();
        chk("bp_load", {32'd0, oaddr[0]}, 64'h2008);
        o_rdy = 1'b0;
        for (int t = 0; t < 5; t++) begin
            rand_fields();
            cyc();
            chk("bp_hold_addr", {32'd0, oaddr[0]}, 64'h2008);
            chk("bp_hold_valid", {63'd0, ov[0]}, 64'd1);
        end
        o_rdy = 1'b1;
        wr_addr = 32'h3000;
        cyc();
        chk("bp_release_next", {32'd0, oaddr[0]}, 64'h3000);

        // Randomized traffic with random backpressure.
        for (int t = 0; t < 200; t++) begin
            rd_v  = ($urandom_range(0, 3) != 0);
            wr_v  = ($urandom_range(0, 3) != 0);
            wr_da = ($urandom_range(0, 3) != 0);
            o_rdy = ($urandom_range(0, 4) != 0);
            rand_fields();
            cyc();
        end

        // Alternating single requests: zero-turnaround instance never bubbles.
        o_rdy = 1'b1; wr_da = 1'b1;
        for (int t = 0; t < 10; t++) begin
            rd_v = (t % 2 == 0);
            wr_v = (t % 2 != 0);
            rand_fields();
            cyc();
            chk("tc0_no_bubble", 64'(g_last[1]), (t % 2 == 0) ? 64'd1 : 64'd2);
        end

        // Reset while in TURN with a held output.
        do_reset();
        rd_v = 1'b1; wr_v = 1'b1; wr_da = 1'b1; o_rdy = 1'b1;
        for (int t = 0; t < 8; t++) begin
            rand_fields();
            cyc();
        end
        o_rdy = 1'b0;
        cyc();
        chk("turn_mode", {62'd0, mode[0]}, 64'd3);
        chk("turn_out_valid", {63'd0, ov[0]}, 64'd1);
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        chk("rst_turn_out_valid", {63'd0, ov[0]}, 64'd0);
        chk("rst_turn_mode", {62'd0, mode[0]}, 64'd0);
        wr_v = 1'b0; o_rdy = 1'b1;
        rd_addr = 32'h0000_4440;
        cyc();
        chk("post_rst_read", {62'd0, ov[0], owr[0]}, 64'd2);
        chk("post_rst_addr", {32'd0, oaddr[0]}, 64'h4440);
        rd_v = 1'b0;
        cyc();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
